// File: rtl/spi_pkg.sv
// spi_pkg: shared frame constants, register addresses and FSM encoding
package spi_pkg;
  localparam int FRAME_BITS = 16;
  localparam int NUM_REGS = 5;
  localparam logic [4:0] COUNT_SAT = 5'd17;
  localparam int ADDR_EN_OUT_LO = 0;
  localparam int ADDR_EN_OUT_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_PWM_DUTY = 4;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;
endpackage

// File: rtl/spi_peripheral_if.sv
// spi_peripheral_if: SPI pins in, pwm control registers out
interface spi_peripheral_if;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  modport slave (
    input  sclk, copi, ncs,
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle
  );
  modport master (
    output sclk, copi, ncs,
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle
  );
endinterface

// File: rtl/spi_input_sync.sv
// spi_input_sync: multi-flop synchroniser with one trailing flop for edge detection
module spi_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;
  // shift the async input through the chain; prev_q holds last cycle's synced value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end
  assign sync_o = chain_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;
endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: write-only SPI slave register bank feeding pwm_peripheral
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input logic             clk,
  input logic             rst_n,
  spi_peripheral_if.slave bus
);
  logic sclk_sync, sclk_rise, sclk_fall;
  logic copi_sync, copi_rise, copi_fall;
  logic ncs_sync, ncs_rise, ncs_fall;
  logic unused;
  state_t state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [4:0] count_q, count_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];
  logic write_ok;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(bus.sclk), .sync_o(sclk_sync), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_copi (
    .clk(clk), .rst_n(rst_n), .d_i(bus.copi), .sync_o(copi_sync), .rise_o(copi_rise), .fall_o(copi_fall)
  );
  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ncs (
    .clk(clk), .rst_n(rst_n), .d_i(bus.ncs), .sync_o(ncs_sync), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );

  assign unused = ^{sclk_sync, sclk_fall, copi_rise, copi_fall, ncs_sync};
  assign write_ok = (count_q == 5'(FRAME_BITS)) && shift_q[FRAME_BITS-1] && (shift_q[14:8] <= MAX_ADDR);

  // state, shifter, counter and register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      regs_q  <= regs_d;
    end
  end

  // frame FSM: ncs rise takes priority over a coincident sclk rise
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    regs_d  = regs_q;
    case (state_q)
      IDLE: if (ncs_fall) begin
        shift_d = '0;
        count_d = '0;
        state_d = SHIFT;
      end
      SHIFT: if (ncs_rise) state_d = COMMIT;
      else if (sclk_rise) begin
        shift_d = {shift_q[FRAME_BITS-2:0], copi_sync};
        count_d = (count_q == COUNT_SAT) ? COUNT_SAT : count_q + 5'd1;
      end
      COMMIT: begin
        state_d = IDLE;
        for (int i = 0; i < NUM_REGS; i++)
          if (write_ok && shift_q[14:8] == 7'(i)) regs_d[i] = shift_q[7:0];
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
  assign bus.en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
  assign bus.en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO];
  assign bus.en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
  assign bus.pwm_duty_cycle  = regs_q[ADDR_PWM_DUTY];
endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed SPI frame tests against hand-computed register images
module tb_spi_peripheral;
  localparam int SYNC = 2;
  localparam int HALF = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  spi_peripheral_if bus ();
  logic [39:0] regs;

  spi_peripheral #(.SYNC_STAGES(SYNC), .MAX_ADDR(7'h04)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  assign regs = {bus.pwm_duty_cycle, bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0, bus.en_reg_out_15_8, bus.en_reg_out_7_0};

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame();
    bus.ncs = 1'b0;
    wait_neg(HALF);
  endtask

  task automatic shift_bits(input logic [15:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      bus.copi = (i < 16) ? f[15-i] : 1'b0;
      wait_neg(HALF);
      bus.sclk = 1'b1;
      wait_neg(HALF);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic end_frame(input int post);
    wait_neg(HALF);
    bus.ncs = 1'b1;
    wait_neg(post);
  endtask

  task automatic send_frame(input logic [15:0] f, input int nbits, input int post);
    start_frame();
    shift_bits(f, 0, nbits - 1);
    end_frame(post);
  endtask

  task automatic test_reset();
    wait_neg(4);
    vectors++;
    if (regs !== 40'h0) begin
      miscompares++;
      $display("FAIL reset_regs got %h want %h", regs, 40'h0);
    end
    rst_n = 1'b1;
    wait_neg(6);
  endtask

  task automatic test_write_first();
    send_frame(16'h80FF, 16, SYNC + 1);
    vectors++;
    if (regs !== 40'h0) begin
      miscompares++;
      $display("FAIL early_write got %h want %h", regs, 40'h0);
    end
    wait_neg(2);
    vectors++;
    if (regs !== 40'h00_00_00_00_FF) begin
      miscompares++;
      $display("FAIL write_80FF got %h want %h", regs, 40'h00_00_00_00_FF);
    end
    wait_neg(6);
  endtask

  task automatic test_multi();
    send_frame(16'h8480, 16, 10);
    vectors++;
    if (regs !== 40'h80_00_00_00_FF) begin
      miscompares++;
      $display("FAIL write_8480 got %h want %h", regs, 40'h80_00_00_00_FF);
    end
    send_frame(16'h8201, 16, 10);
    vectors++;
    if (regs !== 40'h80_00_01_00_FF) begin
      miscompares++;
      $display("FAIL write_8201 got %h want %h", regs, 40'h80_00_01_00_FF);
    end
  endtask

  task automatic test_discard();
    send_frame(16'h00AA, 16, 10);
    vectors++;
    if (regs !== 40'h80_00_01_00_FF) begin
      miscompares++;
      $display("FAIL read_frame got %h want %h", regs, 40'h80_00_01_00_FF);
    end
    send_frame(16'h85AA, 16, 10);
    vectors++;
    if (regs !== 40'h80_00_01_00_FF) begin
      miscompares++;
      $display("FAIL bad_addr got %h want %h", regs, 40'h80_00_01_00_FF);
    end
  endtask

  task automatic test_bad_length();
    send_frame(16'h81AA, 15, 10);
    vectors++;
    if (regs !== 40'h80_00_01_00_FF) begin
      miscompares++;
      $display("FAIL short_frame got %h want %h", regs, 40'h80_00_01_00_FF);
    end
    send_frame(16'h81AA, 17, 10);
    vectors++;
    if (regs !== 40'h80_00_01_00_FF) begin
      miscompares++;
      $display("FAIL long_frame got %h want %h", regs, 40'h80_00_01_00_FF);
    end
    send_frame(16'h81AA, 16, 10);
    vectors++;
    if (regs !== 40'h80_00_01_AA_FF) begin
      miscompares++;
      $display("FAIL good_after_bad got %h want %h", regs, 40'h80_00_01_AA_FF);
    end
  endtask

  task automatic test_coincident_edges();
    start_frame();
    shift_bits(16'h8433, 0, 15);
    bus.copi = 1'b1;
    wait_neg(HALF);
    bus.sclk = 1'b1;
    bus.ncs = 1'b1;
    wait_neg(10);
    bus.sclk = 1'b0;
    wait_neg(4);
    vectors++;
    if (regs !== 40'h33_00_01_AA_FF) begin
      miscompares++;
      $display("FAIL ncs_wins got %h want %h", regs, 40'h33_00_01_AA_FF);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(16'h8011, 16, 3);
    send_frame(16'h8122, 16, 10);
    vectors++;
    if (regs !== 40'h33_00_01_22_11) begin
      miscompares++;
      $display("FAIL back_to_back got %h want %h", regs, 40'h33_00_01_22_11);
    end
  endtask

  task automatic test_reset_midframe();
    send_frame(16'h8355, 16, 10);
    vectors++;
    if (regs !== 40'h33_55_01_22_11) begin
      miscompares++;
      $display("FAIL pre_reset got %h want %h", regs, 40'h33_55_01_22_11);
    end
    start_frame();
    shift_bits(16'h83C3, 0, 7);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (regs !== 40'h0) begin
      miscompares++;
      $display("FAIL async_reset got %h want %h", regs, 40'h0);
    end
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(2);
    shift_bits(16'h83C3, 8, 15);
    end_frame(10);
    vectors++;
    if (regs !== 40'h0) begin
      miscompares++;
      $display("FAIL interrupted_frame got %h want %h", regs, 40'h0);
    end
    send_frame(16'h83C3, 16, 10);
    vectors++;
    if (regs !== 40'h00_C3_00_00_00) begin
      miscompares++;
      $display("FAIL after_reset got %h want %h", regs, 40'h00_C3_00_00_00);
    end
  endtask

  initial begin
    bus.sclk = 1'b0;
    bus.copi = 1'b0;
    bus.ncs = 1'b1;
    test_reset();
    test_write_first();
    test_multi();
    test_discard();
    test_bad_length();
    test_coincident_edges();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
